// File: rtl/alu_pkg.sv
// ALU control encodings shared by the arbiter and the instruction decoder.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1110;

   // True for the codes the ALU actually implements; anything else yields x from the ALU.
   function automatic logic is_legal_ctrl(input logic [3:0] c);
      case (c)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
         ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [N-1:0] i_req,
   input  logic         i_advance,
   output logic [N-1:0] o_grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_gidx;
   logic          w_found;

   // First requester at or after the pointer, wrapping modulo N.
   always_comb begin
      o_grant = '0;
      w_idx   = '0;
      w_gidx  = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_idx = PW'((int'(r_ptr) + k) % N);
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_gidx         = w_idx;
            w_found        = 1'b1;
         end
      end
   end

   // Pointer moves just past the winner so it becomes lowest priority next cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ptr <= '0;
      else if (i_advance && w_found)
         r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant, operand mux,
// per-requester registered response buffers with illegal-code flagging.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NREQ-1:0]   i_req_valid,
   output logic [NREQ-1:0]   o_req_ready,
   input  logic [NREQ*W-1:0] i_req_a,
   input  logic [NREQ*W-1:0] i_req_b,
   input  logic [NREQ*4-1:0] i_req_ctrl,
   output logic [NREQ-1:0]   o_rsp_valid,
   input  logic [NREQ-1:0]   i_rsp_ready,
   output logic [NREQ*W-1:0] o_rsp_result,
   output logic [NREQ-1:0]   o_rsp_zero,
   output logic [NREQ-1:0]   o_rsp_err,
   output logic [W-1:0]      o_alu_a,
   output logic [W-1:0]      o_alu_b,
   output logic [3:0]        o_alu_ctrl,
   input  logic [W-1:0]      i_alu_result,
   input  logic              i_alu_zero
);

   logic                     r_rst_meta;
   logic                     r_rst_n;
   logic [NREQ-1:0]          r_rsp_valid;
   logic [NREQ-1:0]          r_rsp_zero;
   logic [NREQ-1:0]          r_rsp_err;
   logic [NREQ-1:0][W-1:0]   r_rsp_result;

   logic [NREQ-1:0]          w_elig;
   logic [NREQ-1:0]          w_grant;
   logic [W-1:0]             w_a;
   logic [W-1:0]             w_b;
   logic [3:0]               w_ctrl;
   logic                     w_legal;

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) {r_rst_meta, r_rst_n} <= 2'b00;
      else          {r_rst_meta, r_rst_n} <= {1'b1, r_rst_meta};
   end

   // A requester may go if its buffer is empty or being drained this cycle;
   // nothing is eligible while reset is held, so req_ready drops immediately.
   assign w_elig = i_req_valid & (~r_rsp_valid | i_rsp_ready) & {NREQ{r_rst_n}};

   rr_arbiter #(.N(NREQ)) u_rr (
      .i_clk     (i_clk),
      .i_rst_n   (r_rst_n),
      .i_req     (w_elig),
      .i_advance (1'b1),
      .o_grant   (w_grant)
   );

   // One-hot operand mux; idle ALU inputs are driven to zero.
   always_comb begin
      w_a    = '0;
      w_b    = '0;
      w_ctrl = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_a    = i_req_a[i*W +: W];
            w_b    = i_req_b[i*W +: W];
            w_ctrl = i_req_ctrl[i*4 +: 4];
         end
      end
   end

   assign w_legal = is_legal_ctrl(w_ctrl);

   // Response buffers: load on grant (illegal codes never capture the ALU's x),
   // otherwise drain on rsp_ready; contents hold while stalled.
   always_ff @(posedge i_clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_rsp_valid  <= '0;
         r_rsp_zero   <= '0;
         r_rsp_err    <= '0;
         r_rsp_result <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
               r_rsp_valid[i]  <= 1'b1;
               r_rsp_err[i]    <= ~w_legal;
               r_rsp_result[i] <= w_legal ? i_alu_result : '0;
               r_rsp_zero[i]   <= w_legal & i_alu_zero;
            end else if (i_rsp_ready[i]) begin
               r_rsp_valid[i]  <= 1'b0;
            end
         end
      end
   end

   assign o_req_ready  = w_grant;
   assign o_alu_a      = w_a;
   assign o_alu_b      = w_b;
   assign o_alu_ctrl   = w_ctrl;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_result = r_rsp_result;
   assign o_rsp_zero   = r_rsp_zero;
   assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural ALU and a transaction-level reference model.
module tb_alu_arbiter;

   localparam int N = 2;
   localparam int W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_err;
   logic [N*W-1:0]    req_a, req_b, rsp_result;
   logic [N*4-1:0]    req_ctrl;
   logic [W-1:0]      alu_a, alu_b, alu_result;
   logic [3:0]        alu_ctrl;
   logic              alu_zero;

   int nvec = 0;
   int nerr = 0;

   // stimulus for the next cycle
   logic [W-1:0] s_a [N];
   logic [W-1:0] s_b [N];
   logic [3:0]   s_c [N];
   logic [N-1:0] s_v, s_r;

   // reference model state
   int           m_ptr;
   bit           m_v [N];
   logic [W-1:0] m_res [N];
   bit           m_z [N];
   bit           m_e [N];

   // optional literal expectation for requester 0 at the next check point
   bit           lit_on = 1'b0;
   logic [W-1:0] lit_res;
   bit           lit_z, lit_e;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(N), .W(W)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_ctrl(req_ctrl),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
      .i_alu_result(alu_result), .i_alu_zero(alu_zero)
   );

   function automatic bit legal_ref(input logic [3:0] c);
      return c inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'hE};
   endfunction

   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] c);
      case (c)
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h2:    return a & b;
         4'h3:    return a | b;
         4'h5:    return ($signed(a) < $signed(b)) ? 1 : 0;
         4'h6:    return a << b[4:0];
         4'h8:    return a >> b[4:0];
         4'hE:    return $signed(a) >>> b[4:0];
         default: return 'x;
      endcase
   endfunction

   // Behavioural ALU outside the block; illegal codes produce x.
   always_comb begin
      alu_result = alu_ref(alu_a, alu_b, alu_ctrl);
      alu_zero   = legal_ref(alu_ctrl) ? (alu_result == '0) : 1'bx;
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_res[i] = '0; m_z[i] = 0; m_e[i] = 0;
      end
   endtask

   // Every output must read zero while reset is held.
   task automatic chk_reset_outputs(input string tag);
      chk({tag, " req_ready"}, W'(req_ready), '0);
      chk({tag, " rsp_valid"}, W'(rsp_valid), '0);
      chk({tag, " rsp_zero"},  W'(rsp_zero),  '0);
      chk({tag, " rsp_err"},   W'(rsp_err),   '0);
      for (int i = 0; i < N; i++)
         chk($sformatf("%s rsp_result[%0d]", tag, i), rsp_result[i*W +: W], '0);
      chk({tag, " alu_a"},    alu_a, '0);
      chk({tag, " alu_b"},    alu_b, '0);
      chk({tag, " alu_ctrl"}, W'(alu_ctrl), '0);
   endtask

   // One clock: drive at negedge, check outputs, then advance the model over the posedge.
   task automatic cycle();
      int           g;
      int           idx;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      req_valid = s_v;
      rsp_ready = s_r;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W]   = s_a[i];
         req_b[i*W +: W]   = s_b[i];
         req_ctrl[i*4 +: 4] = s_c[i];
      end
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rsp_valid[%0d]", i), W'(rsp_valid[i]), W'(m_v[i]));
         if (m_v[i]) begin
            chk($sformatf("rsp_result[%0d]", i), rsp_result[i*W +: W], m_res[i]);
            chk($sformatf("rsp_zero[%0d]", i), W'(rsp_zero[i]), W'(m_z[i]));
            chk($sformatf("rsp_err[%0d]", i), W'(rsp_err[i]), W'(m_e[i]));
         end
      end
      if (lit_on) begin
         chk("literal result", rsp_result[W-1:0], lit_res);
         chk("literal zero", W'(rsp_zero[0]), W'(lit_z));
         chk("literal err", W'(rsp_err[0]), W'(lit_e));
         lit_on = 1'b0;
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (g < 0 && s_v[idx] && (!m_v[idx] || s_r[idx])) g = idx;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", W'(req_ready), W'(exp_rdy));
      chk("alu_a", alu_a, (g >= 0) ? s_a[g] : '0);
      chk("alu_b", alu_b, (g >= 0) ? s_b[g] : '0);
      chk("alu_ctrl", W'(alu_ctrl), (g >= 0) ? W'(s_c[g]) : '0);
      for (int i = 0; i < N; i++) begin
         if (i == g) begin
            m_v[i] = 1;
            if (legal_ref(s_c[i])) begin
               m_res[i] = alu_ref(s_a[i], s_b[i], s_c[i]);
               m_z[i]   = (m_res[i] == '0);
               m_e[i]   = 0;
            end else begin
               m_res[i] = '0; m_z[i] = 0; m_e[i] = 1;
            end
         end else if (s_r[i]) begin
            m_v[i] = 0;
         end
      end
      if (g >= 0) m_ptr = (g + 1) % N;
   endtask

   // Single op on requester 0 with its response consumed the following cycle;
   // the spec-given result is checked at the next check point.
   task automatic op0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                      input logic [W-1:0] er, input bit ez, input bit ee);
      s_v = 2'b01; s_r = 2'b01;
      s_a[0] = a; s_b[0] = b; s_c[0] = c;
      cycle();
      lit_on = 1'b1; lit_res = er; lit_z = ez; lit_e = ee;
   endtask

   task automatic idle();
      s_v = '0; s_r = '1;
      cycle();
   endtask

   initial begin
      s_v = '0; s_r = '0;
      for (int i = 0; i < N; i++) begin s_a[i] = '0; s_b[i] = '0; s_c[i] = '0; end
      req_valid = 2'b11; rsp_ready = '0; req_a = '0; req_b = '0; req_ctrl = '0;
      model_reset();

      // reset state, with requests pending
      repeat (2) @(negedge clk);
      #1 chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1; req_valid = '0;
      repeat (3) @(posedge clk);

      // contention from pointer 0: grants 0,1,0,1
      s_v = 2'b11; s_r = 2'b11;
      s_a[0] = 10; s_b[0] = 4; s_c[0] = 4'h1;
      s_a[1] = 6;  s_b[1] = 6; s_c[1] = 4'h0;
      repeat (4) cycle();
      idle();

      // single request and directed op results
      op0(32'd5, 32'd3, 4'b0001, 32'd2, 0, 0);
      op0(32'h8000_0000, 32'd1, 4'b1110, 32'hC000_0000, 0, 0);
      op0(32'h8000_0000, 32'd1, 4'b1000, 32'h4000_0000, 0, 0);
      op0(32'hFFFF_FFFF, 32'd1, 4'b0101, 32'd1, 0, 0);
      op0(32'd7, 32'd7, 4'b0001, 32'd0, 1, 0);
      // illegal code accepted with err, next legal op clears it
      op0(32'd9, 32'd2, 4'b0100, 32'd0, 0, 1);
      op0(32'd9, 32'd2, 4'b0000, 32'd11, 0, 0);
      idle();

      // back-pressure on requester 0; requester 1 keeps flowing
      s_v = 2'b11; s_r = 2'b10;
      for (int k = 0; k < 6; k++) begin
         s_a[0] = 100 + k; s_b[0] = 1; s_c[0] = 4'h0;
         s_a[1] = 200 + k; s_b[1] = k; s_c[1] = 4'h6;
         cycle();
      end
      idle();

      // randomized traffic, including illegal codes and zero results
      for (int k = 0; k < 300; k++) begin
         s_v = N'($urandom);
         s_r = N'($urandom);
         for (int i = 0; i < N; i++) begin
            s_a[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            s_b[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            s_c[i] = 4'($urandom_range(0, 15));
         end
         cycle();
      end
      idle();

      // reset mid-operation: both buffers full and a grant in progress
      s_v = 2'b11; s_r = 2'b00;
      s_a[0] = 1; s_b[0] = 2; s_c[0] = 4'h0;
      s_a[1] = 3; s_b[1] = 4; s_c[1] = 4'h3;
      repeat (2) cycle();
      @(negedge clk);
      rsp_ready = 2'b11;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1; req_valid = '0;
      repeat (3) @(posedge clk);
      s_v = 2'b11; s_r = 2'b11;
      cycle();
      chk("first grant after reset", W'(req_ready), W'(2'b01));
      repeat (3) cycle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Hard stop in case anything stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
